// File: rtl/rv_multicycle_controller.sv
// Multicycle RV32I control FSM driving a shared-memory datapath (unified memory port).
// Optional M-extension handshake (MULDIV state, md_start/md_done) enabled by `define RV_MULDIV_EN.
module rv_multicycle_controller #(
    parameter int ALU_CTRL_W   = 4,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  alu_zero,
    input  logic                  alu_lt,
    input  logic                  alu_ltu,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            imm_src,
    output logic [1:0]            result_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  instr_done,
    output logic                  illegal_instr,
`ifdef RV_MULDIV_EN
    output logic                  md_start,
    input  logic                  md_done,
`endif
    output logic                  mem_fault
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef RV_MULDIV_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam int              CNT_W      = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic            TIMEOUT_EN = (WAIT_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_LUI    = 4'd12,
        S_AUIPC  = 4'd13,
        S_MULDIV = 4'd14
    } state_e;

    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [3:0] branch_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3[2:1])
            2'b00:   op = ALU_SUB;
            2'b10:   op = ALU_SLT;
            2'b11:   op = ALU_SLTU;
            default: op = ALU_SUB;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic lt, input logic ltu);
        logic cond;
        case (f3[2:1])
            2'b00:   cond = z;
            2'b10:   cond = lt;
            2'b11:   cond = ltu;
            default: cond = 1'b0;
        endcase
        return cond ^ f3[0];
    endfunction

    function automatic logic funct_legal(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
        logic ok;
        case (op)
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
            OP_R: begin
                if (f7 == F7_BASE) begin
                    ok = 1'b1;
                end else if (f7 == F7_ALT) begin
                    ok = (f3 == 3'b000) || (f3 == 3'b101);
`ifdef RV_MULDIV_EN
                end else if (f7 == F7_MULDIV) begin
                    ok = 1'b1;
`endif
                end else begin
                    ok = 1'b0;
                end
            end
            OP_IMM: begin
                case (f3)
                    3'b001:  ok = (f7 == F7_BASE);
                    3'b101:  ok = (f7 == F7_BASE) || (f7 == F7_ALT);
                    default: ok = 1'b1;
                endcase
            end
            OP_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    logic              fault_q, fault_d;
    logic              wait_state_s;
    logic              ready_s;
    logic              timed_out_s;
    logic              handshake_s;
    logic [3:0]        alu_op_s;
`ifdef RV_MULDIV_EN
    logic              md_first_q, md_first_d;

    assign wait_state_s = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                          (state_q == S_MEMWR) || (state_q == S_MULDIV);
    assign ready_s      = (state_q == S_MULDIV) ? md_done : mem_ready;
`else
    assign wait_state_s = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign ready_s      = mem_ready;
`endif

    // A wait that has used up its budget ignores any late ready and returns to FETCH.
    assign timed_out_s = TIMEOUT_EN && wait_state_s && (cnt_q == CNT_LIMIT);
    assign handshake_s = wait_state_s && ready_s && !timed_out_s;
    assign alu_ctrl    = ALU_CTRL_W'(alu_op_s);

    // State register, wait counter and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            cnt_q      <= {CNT_W{1'b0}};
            illegal_q  <= 1'b0;
            fault_q    <= 1'b0;
`ifdef RV_MULDIV_EN
            md_first_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            illegal_q  <= illegal_d;
            fault_q    <= fault_d;
`ifdef RV_MULDIV_EN
            md_first_q <= md_first_d;
`endif
        end
    end

    // Next-state, wait counter and sticky flag update.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        cnt_d     = {CNT_W{1'b0}};
        if (timed_out_s) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_d = handshake_s ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if (!funct_legal(opcode, funct3, funct7)) begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        case (opcode)
                            OP_LOAD, OP_STORE: state_d = S_MEMADR;
`ifdef RV_MULDIV_EN
                            OP_R:      state_d = (funct7 == F7_MULDIV) ? S_MULDIV : S_EXEC_R;
`else
                            OP_R:      state_d = S_EXEC_R;
`endif
                            OP_IMM:    state_d = S_EXEC_I;
                            OP_BRANCH: state_d = S_BRANCH;
                            OP_JAL:    state_d = S_JAL;
                            OP_JALR:   state_d = S_JALR;
                            OP_LUI:    state_d = S_LUI;
                            OP_AUIPC:  state_d = S_AUIPC;
                            default:   state_d = S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_d = handshake_s ? S_MEMWB : S_MEMRD;
                S_MEMWB:  state_d = S_FETCH;
                S_MEMWR:  state_d = handshake_s ? S_FETCH : S_MEMWR;
                S_EXEC_R, S_EXEC_I, S_JAL, S_JALR, S_LUI, S_AUIPC: state_d = S_ALUWB;
                S_ALUWB:  state_d = S_FETCH;
                S_BRANCH: state_d = S_FETCH;
`ifdef RV_MULDIV_EN
                S_MULDIV: state_d = handshake_s ? S_ALUWB : S_MULDIV;
`endif
                default:  state_d = S_FETCH;
            endcase
        end
        // The fault becomes visible in the same cycle that the request is dropped.
        if (TIMEOUT_EN && wait_state_s && !ready_s && !timed_out_s) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_LIMIT) begin
                fault_d = 1'b1;
            end else begin
                fault_d = fault_q;
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

`ifdef RV_MULDIV_EN
    assign md_first_d = (state_d == S_MULDIV) && (state_q != S_MULDIV);
`endif

    // Control decode; everything idles at 0 while reset is held or after a timeout.
    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        imm_src       = IMM_I;
        result_src    = 2'b00;
        alu_op_s      = ALU_ADD;
        instr_done    = 1'b0;
        illegal_instr = illegal_q;
        mem_fault     = fault_q;
`ifdef RV_MULDIV_EN
        md_start      = 1'b0;
`endif
        if (rst_n && !timed_out_s) begin
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = handshake_s;
                    pc_write   = handshake_s;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_B;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_req    = 1'b1;
                    mem_write  = 1'b1;
                    adr_src    = 1'b1;
                    instr_done = handshake_s;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_op_s  = arith_op(funct3, funct7[5]);
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op_s  = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
`ifdef RV_MULDIV_EN
                    result_src = ((opcode == OP_R) && (funct7 == F7_MULDIV)) ? 2'b10 : 2'b00;
`endif
                end
                S_BRANCH: begin
                    alu_src_a  = 2'b10;
                    alu_op_s   = branch_op(funct3);
                    pc_write   = branch_taken(funct3, alu_zero, alu_lt, alu_ltu);
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    imm_src   = IMM_J;
                    pc_write  = 1'b1;
                end
                S_JALR: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    pc_write   = 1'b1;
                    result_src = 2'b10;
                end
                S_LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_U;
                end
                S_AUIPC: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_U;
                end
`ifdef RV_MULDIV_EN
                S_MULDIV: begin
                    alu_src_a = 2'b10;
                    md_start  = md_first_q;
                end
`endif
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end else begin
            mem_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_multicycle_controller.sv
// Randomized bench for rv_multicycle_controller: a per-instruction procedural model predicts
// every control output each cycle; directed cases pin retire latency, branches, flags and reset.
module tb_rv_multicycle_controller;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_zero, alu_lt, alu_ltu, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;
    logic       instr_done, illegal_instr, mem_fault;

    always #5 clk = ~clk;

    rv_multicycle_controller #(.ALU_CTRL_W(4), .WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src),
        .alu_ctrl(alu_ctrl), .instr_done(instr_done), .illegal_instr(illegal_instr),
        .mem_fault(mem_fault)
    );

    logic [21:0] act;
    assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_src_a,
                  alu_src_b, imm_src, result_src, alu_ctrl, instr_done, illegal_instr, mem_fault};

    int   errors = 0;
    int   checks = 0;
    int   cyc, done_cyc, rw_count;
    logic exp_ill, exp_fault, last_pcw;
    bit   hold_flags = 1'b0;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                           ITYPE = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd5, A_SLTU = 4'd6;

    function automatic logic [19:0] mk(input logic req, input logic wr, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic [1:0] rs,
                                       input logic [3:0] alu, input logic done);
        return {req, wr, adr, irw, pcw, rw, sa, sb, imm, rs, alu, done};
    endfunction

    // ALU encoding table indexed by funct3: ADD SLL SLT SLTU XOR SRL OR AND.
    function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic alt);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd9;
        return tbl[f3];
    endfunction

    function automatic bit exp_legal(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7);
        if (op == RTYPE) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (op == ITYPE) begin
            if (f3 == 3'd1) return f7 == 7'h00;
            if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
            return 1'b1;
        end
        if (op == BR) return !(f3 == 3'd2 || f3 == 3'd3);
        return op == LOAD || op == STORE || op == JAL || op == JALR || op == LUI || op == AUIPC;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Called just after a rising edge; checks on the falling edge, returns after the next rise.
    task automatic step(input string name, input logic [19:0] e);
        @(negedge clk);
        check(name, 32'(act), 32'({e, exp_ill, exp_fault}));
        cyc++;
        if (instr_done === 1'b1) done_cyc = cyc;
        if (reg_write === 1'b1) rw_count++;
        last_pcw = pc_write;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_idle();
        mem_ready = 1'($urandom_range(0, 1));
        if (!hold_flags) begin
            alu_zero = 1'($urandom_range(0, 1));
            alu_lt   = 1'($urandom_range(0, 1));
            alu_ltu  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic fetch_and_decode(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input int fw);
        cyc = 0; done_cyc = 0; rw_count = 0;
        for (int i = 0; i < fw; i++) begin
            rnd_idle(); mem_ready = 1'b0;
            step("fetch_wait", mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'd0, 2'b10, A_ADD, 0));
        end
        rnd_idle(); mem_ready = 1'b1;
        step("fetch", mk(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 3'd0, 2'b10, A_ADD, 0));
        opcode = op; funct3 = f3; funct7 = f7;
        rnd_idle();
        step("decode", mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'd2, 2'b00, A_ADD, 0));
    endtask

    task automatic aluwb();
        rnd_idle();
        step("aluwb", mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'd0, 2'b00, A_ADD, 1));
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int fw, input int mw);
        logic       taken;
        logic [3:0] bop;
        fetch_and_decode(op, f3, f7, fw);
        if (!exp_legal(op, f3, f7)) begin
            exp_ill = 1'b1;
        end else if (op == LOAD || op == STORE) begin
            rnd_idle();
            step("memadr", mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, (op == STORE) ? 3'd1 : 3'd0,
                              2'b00, A_ADD, 0));
            for (int i = 0; i < mw; i++) begin
                rnd_idle(); mem_ready = 1'b0;
                step("mem_wait", mk(1, op == STORE, 1, 0, 0, 0, 2'b00, 2'b00, 3'd0, 2'b00, A_ADD, 0));
            end
            rnd_idle(); mem_ready = 1'b1;
            step("mem_ready", mk(1, op == STORE, 1, 0, 0, 0, 2'b00, 2'b00, 3'd0, 2'b00, A_ADD,
                                 op == STORE));
            if (op == LOAD) begin
                rnd_idle();
                step("memwb", mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'd0, 2'b01, A_ADD, 1));
            end
        end else if (op == BR) begin
            rnd_idle();
            case (f3)
                3'd0: begin taken = alu_zero;  bop = A_SUB;  end
                3'd1: begin taken = !alu_zero; bop = A_SUB;  end
                3'd4: begin taken = alu_lt;    bop = A_SLT;  end
                3'd5: begin taken = !alu_lt;   bop = A_SLT;  end
                3'd6: begin taken = alu_ltu;   bop = A_SLTU; end
                default: begin taken = !alu_ltu; bop = A_SLTU; end
            endcase
            step("branch", mk(0, 0, 0, 0, taken, 0, 2'b10, 2'b00, 3'd0, 2'b00, bop, 1));
        end else begin
            rnd_idle();
            case (op)
                RTYPE: step("exec_r", mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'd0, 2'b00,
                                         exp_alu(f3, f7[5]), 0));
                ITYPE: step("exec_i", mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'd0, 2'b00,
                                         exp_alu(f3, f3 == 3'd5 && f7[5]), 0));
                JAL:   step("jal", mk(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 3'd4, 2'b00, A_ADD, 0));
                JALR:  step("jalr", mk(0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 3'd0, 2'b10, A_ADD, 0));
                LUI:   step("lui", mk(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 3'd3, 2'b00, A_ADD, 0));
                default: step("auipc", mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'd3, 2'b00, A_ADD, 0));
            endcase
            aluwb();
        end
    endtask

    initial begin
        logic [6:0] ops [11];
        logic [6:0] f7r;
        ops = '{LOAD, STORE, RTYPE, ITYPE, BR, JAL, JALR, LUI, AUIPC, 7'b0000000, 7'b1111111};
        rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = 1'b1;
        exp_ill = 1'b0; exp_fault = 1'b0;
        #1 check("reset_outputs", 32'(act), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr(RTYPE, 3'd0, 7'h00, 0, 0);
        check("add_retire_cycle", done_cyc, 4);
        check("add_reg_writes", rw_count, 1);
        run_instr(LOAD, 3'd2, 7'h00, 0, 3);
        check("lw_retire_cycle", done_cyc, 8);
        hold_flags = 1'b1; alu_zero = 1'b1; alu_lt = 1'b0; alu_ltu = 1'b0;
        run_instr(BR, 3'd0, 7'h00, 0, 0);
        check("beq_taken", 32'(last_pcw), 32'd1);
        run_instr(BR, 3'd1, 7'h00, 0, 0);
        check("bne_not_taken", 32'(last_pcw), 32'd0);
        hold_flags = 1'b0;

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: f7r = 7'h00;
                1: f7r = 7'h20;
                2: f7r = 7'h01;
                default: f7r = 7'($urandom);
            endcase
            run_instr(ops[$urandom_range(0, 10)], 3'($urandom), f7r,
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        run_instr(7'b0000000, 3'd0, 7'h00, 0, 0);
        check("illegal_opcode_flag", 32'(illegal_instr), 32'd1);
        run_instr(RTYPE, 3'd0, 7'h21, 1, 0);
        check("illegal_funct7_retire", done_cyc, 0);
        check("illegal_funct7_no_wb", rw_count, 0);
        check("illegal_sticky", 32'(illegal_instr), 32'd1);

        for (int i = 0; i < TO; i++) begin
            rnd_idle(); mem_ready = 1'b0;
            step("to_wait", mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'd0, 2'b10, A_ADD, 0));
        end
        exp_fault = 1'b1;
        mem_ready = 1'b0;
        step("to_drop", 20'd0);
        check("fault_set", 32'(mem_fault), 32'd1);
        run_instr(ITYPE, 3'd7, 7'h00, 0, 0);
        check("fault_sticky", 32'(mem_fault), 32'd1);

        fetch_and_decode(STORE, 3'd2, 7'h00, 0);
        rnd_idle();
        step("memadr", mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'd1, 2'b00, A_ADD, 0));
        mem_ready = 1'b0;
        step("memwr_wait", mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'd0, 2'b00, A_ADD, 0));
        #2 rst_n = 1'b0;
        #1 check("reset_async_mem_write", 32'(mem_write), 32'd0);
        check("reset_async_all", 32'(act), 32'd0);
        exp_ill = 1'b0; exp_fault = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(RTYPE, 3'd0, 7'h20, 0, 0);
        check("post_reset_sub_retire", done_cyc, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
